bp_counter_table: RTL and testbench
===================================

# bp_counter_table

Pattern history table for the branch predictor. It holds one saturating counter per entry, indexed by PC, and produces a registered taken/not-taken prediction for the fetch stage. It also accepts resolved-branch outcomes from execute and writes each counter back after a single saturating step. Each counter update instantiates `sat_updn` (WIDTH = `WIDTH`) as its read-modify-write datapath.

## Interface
Parameters:
- `LINES`, 32: number of counters. Must be a power of two, ≥ 2.
- `WIDTH`, 2: counter width in bits.
- `PC_WIDTH`, 32: PC width.

Ports:
- `clk` in 1: the single clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pred_valid` in 1: a prediction lookup is requested this cycle.
- `pred_pc` in `PC_WIDTH`: PC to predict.
- `pred_stall` in 1: hold the prediction outputs.
- `pred_out_valid` out 1: `pred_taken` is valid.
- `pred_taken` out 1: predicted direction, the MSB of the counter.
- `upd_valid` in 1: a resolved branch is presented this cycle.
- `upd_pc` in `PC_WIDTH`: PC of the resolved branch.
- `upd_taken` in 1: actual outcome of the resolved branch.

## Operation
- Index: `idx(pc) = pc[log2(LINES)+1 : 2]`. Bits [1:0] are ignored. Higher PC bits alias onto the same entry; there is no tag.
- Storage: `LINES` × `WIDTH` flip-flop array. No SRAM macro is used.
- Reset value of every counter: `2^(WIDTH-1) - 1`, i.e. weakly not-taken. For WIDTH=2 this is 2'b01.
- Update, when `upd_valid`=1: `ctr[idx(upd_pc)] <= sat_updn(in=ctr[idx(upd_pc)], up=upd_taken, dn=!upd_taken)`.
  - Counters saturate at all-ones and at zero; they never wrap.
  - With `upd_valid`=0 no counter changes.
- Prediction, when `pred_valid`=1 and `pred_stall`=0:
  - `pred_taken <= ctr_fwd[idx(pred_pc)][WIDTH-1]`.
  - `pred_out_valid <= 1`.
- When `pred_valid`=0 and `pred_stall`=0: `pred_out_valid <= 0`; `pred_taken` is don't-care and is driven 0.
- When `pred_stall`=1: `pred_out_valid` and `pred_taken` hold their values. `pred_valid` and `pred_pc` are ignored. Updates still proceed during a stall.
- Forwarding: `ctr_fwd` is the post-update counter value whenever `upd_valid`=1 and `idx(upd_pc)==idx(pred_pc)` in the same cycle. Otherwise it is the stored value. The prediction therefore always reflects the update written in the same cycle.

## Timing
- Prediction latency is 1 cycle. `pred_pc` sampled at edge N produces `pred_taken`/`pred_out_valid` after edge N.
- Update latency is 1 cycle. The new counter is visible to a lookup in the cycle after `upd_valid`, or in the same cycle through forwarding.
- Throughput: one lookup and one update per cycle, with no back-pressure on the update port.
- Reset:
  - While `rst`=1 at an edge, all counters are set to the reset value and `pred_out_valid`=0, `pred_taken`=0.
  - Lookups and updates presented in that cycle are discarded, including mid-operation and under `pred_stall`.
  - The first lookup after `rst` deasserts returns not-taken.
- Outputs come only from registers; there is no combinational path from any input to any output.

## Test plan
- Reset then lookup: `rst` for 1 cycle, then `pred_valid`=1 with `pred_pc`=0x100 → next cycle `pred_out_valid`=1, `pred_taken`=0. Repeat for all 32 indices; each returns 0.
- Saturation up: 4 updates with `upd_pc`=0x104, `upd_taken`=1 → counter goes 01→10→11→11. A lookup after the 1st update returns `pred_taken`=1, and the counter stays at 11 after the 4th.
- Saturation down: from 11, 4 updates with `upd_taken`=0 → counter goes 10, 01, 00, 00. A lookup returns 1 after the 1st update and 0 after the 2nd, and the counter stays at 00 with no wrap to 11.
- Same-cycle forwarding and aliasing:
  - Counter at 01; `upd_pc`=0x108 with `upd_taken`=1 and `pred_pc`=0x188 in the same cycle (same index, LINES=32) → `pred_taken`=1 next cycle.
  - With `pred_pc`=0x10C instead → `pred_taken`=0.
- Stall: `pred_taken`=1 registered; assert `pred_stall` for 3 cycles while driving `pred_valid`=1 with `pred_pc` pointing at a not-taken entry → outputs hold at 1/1. An update issued during the stall lands and is visible after the stall.
- Mid-run reset: train entry 0x104 to 11, assert `rst` together with `upd_valid` → after reset, a lookup of 0x104 returns 0, `pred_out_valid`=0 during reset, and the counter is 01.

Source files
------------

// File: rtl/bp_counter_table.sv
// Pattern history table: one saturating counter per PC-indexed entry, with a
// registered prediction that forwards same-cycle updates to the same entry.

module sat_updn #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             up,
    input  logic             dn,
    output logic [WIDTH-1:0] cnt_out
);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Single saturating step; conflicting or absent requests leave the value alone.
    always_comb begin
        cnt_out = cnt_in;
        if (up && !dn && (cnt_in != CNT_MAX)) begin
            cnt_out = cnt_in + CNT_ONE;
        end else if (dn && !up && (cnt_in != CNT_MIN)) begin
            cnt_out = cnt_in - CNT_ONE;
        end else begin
            cnt_out = cnt_in;
        end
    end
endmodule

module bp_counter_table #(
    parameter int LINES    = 32,
    parameter int WIDTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [PC_WIDTH-1:0] pred_pc,
    input  logic                pred_stall,
    output logic                pred_out_valid,
    output logic                pred_taken,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken
);
    localparam int IDX_W = $clog2(LINES);
    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [WIDTH-1:0] CTR_RST = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] ctr_r [LINES];
    logic [IDX_W-1:0] upd_idx_s;
    logic [IDX_W-1:0] pred_idx_s;
    logic [WIDTH-1:0] upd_cur_s;
    logic [WIDTH-1:0] upd_nxt_s;
    logic [WIDTH-1:0] ctr_fwd_s;
    logic             pred_out_valid_r;
    logic             pred_taken_r;
    logic             unused_pc_bits_s;

    assign upd_idx_s  = upd_pc[IDX_W+1:2];
    assign pred_idx_s = pred_pc[IDX_W+1:2];
    assign upd_cur_s  = ctr_r[upd_idx_s];

    // Byte offset and high PC bits do not take part in indexing (no tag).
    assign unused_pc_bits_s = ^{pred_pc[1:0], upd_pc[1:0],
                                pred_pc[PC_WIDTH-1:IDX_W+2], upd_pc[PC_WIDTH-1:IDX_W+2]};

    sat_updn #(.WIDTH(WIDTH)) u_sat_updn (
        .cnt_in  (upd_cur_s),
        .up      (upd_taken),
        .dn      (!upd_taken),
        .cnt_out (upd_nxt_s)
    );

    // Lookup value, bypassing the counter being written this cycle.
    always_comb begin
        ctr_fwd_s = ctr_r[pred_idx_s];
        if (upd_valid && (upd_idx_s == pred_idx_s)) begin
            ctr_fwd_s = upd_nxt_s;
        end else begin
            ctr_fwd_s = ctr_r[pred_idx_s];
        end
    end

    // Counter array write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                ctr_r[i] <= CTR_RST;
            end
        end else if (upd_valid) begin
            ctr_r[upd_idx_s] <= upd_nxt_s;
        end
    end

    // Prediction output registers, held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_out_valid_r <= 1'b0;
            pred_taken_r     <= 1'b0;
        end else if (pred_stall) begin
            pred_out_valid_r <= pred_out_valid_r;
            pred_taken_r     <= pred_taken_r;
        end else if (pred_valid) begin
            pred_out_valid_r <= 1'b1;
            pred_taken_r     <= ctr_fwd_s[WIDTH-1];
        end else begin
            pred_out_valid_r <= 1'b0;
            pred_taken_r     <= 1'b0;
        end
    end

    assign pred_out_valid = pred_out_valid_r;
    assign pred_taken     = pred_taken_r;
endmodule

// File: tb/tb_bp_counter_table.sv
// Directed bench for bp_counter_table: every cycle is compared against an
// arithmetic model of the table, plus literal expectations at key points.

module tb_bp_counter_table;
    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_stall;
    logic        pred_out_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    int checks   = 0;
    int failures = 0;
    int m_ctr [32];
    int m_valid = 0;
    int m_taken = 0;

    always #5 clk = ~clk;

    bp_counter_table #(.LINES(32), .WIDTH(2), .PC_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_stall     (pred_stall),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare at negedge.
    task automatic cyc(input bit r, input bit pv, input logic [31:0] ppc, input bit ps,
                       input bit uv, input logic [31:0] upc, input bit ut);
        int i;
        rst = r; pred_valid = pv; pred_pc = ppc; pred_stall = ps;
        upd_valid = uv; upd_pc = upc; upd_taken = ut;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 32; k++) m_ctr[k] = 1;
            m_valid = 0;
            m_taken = 0;
        end else begin
            if (uv) begin
                i = int'((upc >> 2) % 32);
                if (ut) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
            if (!ps) begin
                if (pv) begin
                    m_valid = 1;
                    m_taken = (m_ctr[int'((ppc >> 2) % 32)] >= 2) ? 1 : 0;
                end else begin
                    m_valid = 0;
                    m_taken = 0;
                end
            end
        end
        @(negedge clk);
        chk("model_pred_out_valid", int'(pred_out_valid), m_valid);
        chk("model_pred_taken", int'(pred_taken), m_taken);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(1'b0, 1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, pc, t);
    endtask

    initial begin
        // Reset, with a lookup presented that must be discarded
        cyc(1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 32'h104, 1'b1);
        chk("reset_valid", int'(pred_out_valid), 0);
        chk("reset_taken", int'(pred_taken), 0);

        look(32'h100);
        chk("first_lookup_valid", int'(pred_out_valid), 1);
        chk("first_lookup_taken", int'(pred_taken), 0);
        for (int k = 0; k < 32; k++) begin
            look(32'(k * 4));
            chk("all_idx_taken", int'(pred_taken), 0);
        end
        idle();
        chk("idle_valid", int'(pred_out_valid), 0);

        // Saturation up on index 1
        upd(32'h104, 1'b1);
        look(32'h104);
        chk("sat_up_first", int'(pred_taken), 1);
        upd(32'h104, 1'b1);
        upd(32'h104, 1'b1);
        upd(32'h104, 1'b1);
        chk("model_sat_hi", m_ctr[1], 3);

        // Saturation down
        upd(32'h104, 1'b0);
        look(32'h104);
        chk("sat_dn_1", int'(pred_taken), 1);
        upd(32'h104, 1'b0);
        look(32'h104);
        chk("sat_dn_2", int'(pred_taken), 0);
        upd(32'h104, 1'b0);
        upd(32'h104, 1'b0);
        chk("model_sat_lo", m_ctr[1], 0);
        upd(32'h104, 1'b1);
        look(32'h104);
        chk("no_wrap", int'(pred_taken), 0);

        // Same-cycle forwarding through an aliased PC (0x188 and 0x108 share index 2)
        cyc(1'b0, 1'b1, 32'h188, 1'b0, 1'b1, 32'h108, 1'b1);
        chk("fwd_alias", int'(pred_taken), 1);
        upd(32'h108, 1'b0);
        cyc(1'b0, 1'b1, 32'h10C, 1'b0, 1'b1, 32'h108, 1'b1);
        chk("fwd_other_idx", int'(pred_taken), 0);

        // Stall holds 1/1; an update during the stall still lands
        look(32'h108);
        chk("pre_stall_taken", int'(pred_taken), 1);
        cyc(1'b0, 1'b1, 32'h10C, 1'b1, 1'b1, 32'h10C, 1'b1);
        chk("stall_valid", int'(pred_out_valid), 1);
        chk("stall_taken", int'(pred_taken), 1);
        cyc(1'b0, 1'b1, 32'h10C, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h10C, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_hold_3", int'(pred_taken), 1);
        look(32'h10C);
        chk("post_stall_upd", int'(pred_taken), 1);

        // Reset under stall clears outputs
        cyc(1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst_stall_valid", int'(pred_out_valid), 0);

        // Mid-run reset discards a concurrent update
        upd(32'h104, 1'b1);
        upd(32'h104, 1'b1);
        look(32'h104);
        chk("trained", int'(pred_taken), 1);
        cyc(1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 32'h104, 1'b1);
        chk("midrst_valid", int'(pred_out_valid), 0);
        look(32'h104);
        chk("midrst_lookup", int'(pred_taken), 0);
        upd(32'h104, 1'b1);
        look(32'h104);
        chk("midrst_ctr_01", int'(pred_taken), 1);

        // Mixed traffic over a few aliasing PCs, checked by the model only
        for (int n = 0; n < 300; n++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 1) * 128),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 7) * 4 + $urandom_range(0, 1) * 128), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
